// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock over a stable window,
// then releases the 50 MHz and 6 MHz domain resets in order. Loss of lock or a lock timeout restarts the sequence.
module pll_reset_seq #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int STAGE_GAP_CYCLES    = 64
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n_0,
  output logic       sys_rst_n_1,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int CNT_MAX_A = (PLL_RST_CYCLES > STAGE_GAP_CYCLES) ? PLL_RST_CYCLES : STAGE_GAP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int SW        = (LOCK_STABLE_CYCLES > 2) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [CW-1:0] RST_LOAD     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STAGE0,
    S_STAGE1,
    S_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          stable_q, stable_d;
  logic [3:0]             retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  logic                   lost_d;
  logic                   pll_rst_q, sys0_q, sys1_q, ready_q, lost_q;

  assign lk_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= RST_LOAD;
      stable_q  <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys0_q    <= 1'b0;
      sys1_q    <= 1'b0;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == S_PLL_RST);
      sys0_q    <= (state_d == S_STAGE0) || (state_d == S_STAGE1) || (state_d == S_RUN);
      sys1_q    <= (state_d == S_STAGE1) || (state_d == S_RUN);
      ready_q   <= (state_d == S_RUN);
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = '0;
    retry_d  = retry_q;
    lost_d   = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock acceptance is tested before the timeout so a coincident finish counts no retry.
        if (lk_s && (stable_q == STABLE_LAST)) begin
          state_d = S_STAGE0;
          cnt_d   = GAP_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_PLL_RST;
          cnt_d   = RST_LOAD;
          if (retry_q != '1) retry_d = retry_q + 4'd1;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          stable_d = lk_s ? (stable_q + 1'b1) : '0;
        end
      end
      S_STAGE0: begin
        if (!lk_s) begin
          state_d = S_PLL_RST;
          cnt_d   = RST_LOAD;
          lost_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_STAGE1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STAGE1: begin
        if (!lk_s) begin
          state_d = S_PLL_RST;
          cnt_d   = RST_LOAD;
          lost_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!lk_s) begin
          state_d = S_PLL_RST;
          cnt_d   = RST_LOAD;
          lost_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n_0 = sys0_q;
  assign sys_rst_n_1 = sys1_q;
  assign ready       = ready_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: expected output-change events (cycle, value) are queued
// by the stimulus and matched by an independent monitor whenever the outputs change.
module tb_pll_reset_seq;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst, sys_rst_n_0, sys_rst_n_1, ready, lock_lost;
  logic [3:0] retry_count;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] prev   = 'x;

  pll_reset_seq #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(50),
    .STAGE_GAP_CYCLES   (5)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n_0(sys_rst_n_0),
    .sys_rst_n_1(sys_rst_n_1),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc++;

  function automatic logic [8:0] mk(input logic pr, input logic s0, input logic s1,
                                    input logic rdy, input logic ll, input logic [3:0] rc);
    return {pr, s0, s1, rdy, ll, rc};
  endfunction

  task automatic push(input int c, input logic [8:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  // Monitor: every change of the output vector is one event to match.
  always @(negedge refclk) begin
    logic [8:0] outs;
    ev_t        e;
    outs = {pll_rst, sys_rst_n_0, sys_rst_n_1, ready, lock_lost, retry_count};
    if (outs !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d outs=%b, required no change", cyc, outs);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== outs) begin
          errors++;
          $display("FAIL event: got cyc=%0d outs=%b, required cyc=%0d outs=%b",
                   cyc, outs, e.cyc, e.v);
        end
      end
      prev = outs;
    end
  end

  initial begin
    int base;
    int rc;
    int t;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    push(1, mk(1, 0, 0, 0, 0, 0));               // reset state
    goto(3);
    rst_n = 1'b1;
    push(7, mk(0, 0, 0, 0, 0, 0));               // pll_rst high 4 cycles

    // Clean lock
    goto(17);
    pll_locked = 1'b1;
    push(27, mk(0, 1, 0, 0, 0, 0));
    push(32, mk(0, 1, 1, 0, 0, 0));
    push(33, mk(0, 1, 1, 1, 0, 0));

    // Lock loss in RUN
    goto(40);
    pll_locked = 1'b0;
    push(43, mk(1, 0, 0, 0, 1, 0));
    push(44, mk(1, 0, 0, 0, 0, 0));
    push(47, mk(0, 0, 0, 0, 0, 0));

    // Bouncing lock: 6 high, 3 low, then steady
    goto(49);
    pll_locked = 1'b1;
    goto(55);
    pll_locked = 1'b0;
    goto(58);
    pll_locked = 1'b1;
    push(68, mk(0, 1, 0, 0, 0, 0));
    push(73, mk(0, 1, 1, 0, 0, 0));
    push(74, mk(0, 1, 1, 1, 0, 0));

    // Lock loss in STAGE0: sys_rst_n_1 must never rise
    goto(80);
    pll_locked = 1'b0;
    push(83, mk(1, 0, 0, 0, 1, 0));
    push(84, mk(1, 0, 0, 0, 0, 0));
    push(87, mk(0, 0, 0, 0, 0, 0));
    goto(87);
    pll_locked = 1'b1;
    push(97, mk(0, 1, 0, 0, 0, 0));
    push(100, mk(1, 0, 0, 0, 1, 0));
    push(101, mk(1, 0, 0, 0, 0, 0));
    push(104, mk(0, 0, 0, 0, 0, 0));
    goto(97);
    pll_locked = 1'b0;

    // Stable completion on the same edge as the timeout
    goto(144);
    pll_locked = 1'b1;
    push(154, mk(0, 1, 0, 0, 0, 0));
    push(159, mk(0, 1, 1, 0, 0, 0));
    push(160, mk(0, 1, 1, 1, 0, 0));

    // Timeout retries with saturation at 15
    goto(170);
    pll_locked = 1'b0;
    push(173, mk(1, 0, 0, 0, 1, 0));
    push(174, mk(1, 0, 0, 0, 0, 0));
    push(177, mk(0, 0, 0, 0, 0, 0));
    base = 177;
    for (int k = 1; k <= 16; k++) begin
      rc = (k > 15) ? 15 : k;
      t  = base + 54 * (k - 1) + 50;
      push(t, mk(1, 0, 0, 0, 0, 4'(rc)));
      push(t + 4, mk(0, 0, 0, 0, 0, 4'(rc)));
    end
    goto(1044);
    pll_locked = 1'b1;
    push(1054, mk(0, 1, 0, 0, 0, 15));
    push(1059, mk(0, 1, 1, 0, 0, 15));
    push(1060, mk(0, 1, 1, 1, 0, 15));

    // Lock loss in RUN leaves retry_count alone
    goto(1070);
    pll_locked = 1'b0;
    push(1073, mk(1, 0, 0, 0, 1, 15));
    push(1074, mk(1, 0, 0, 0, 0, 15));
    push(1077, mk(0, 0, 0, 0, 0, 15));
    goto(1077);
    pll_locked = 1'b1;
    push(1087, mk(0, 1, 0, 0, 0, 15));
    push(1092, mk(0, 1, 1, 0, 0, 15));
    push(1093, mk(0, 1, 1, 1, 0, 15));

    // Asynchronous reset between edges while in RUN
    goto(1100);
    @(posedge refclk);
    #2;
    push(cyc, mk(1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge refclk);
    repeat (5) @(negedge refclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unmatched, required 0 (next cyc=%0d outs=%b)",
               exp_q.size(), exp_q[0].cyc, exp_q[0].v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
